serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  sole clock, rising-edge active.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to begin a subtraction; accepted only while ready=1.
REQ-005 SHALL have port: a  input  WIDTH  minuend, sampled on the accepting edge.
REQ-006 SHALL have port: b  input  WIDTH  subtrahend, sampled on the accepting edge.
REQ-007 SHALL have port: bin  input  1  borrow-in, sampled on the accepting edge.
REQ-008 SHALL have port: ready  output  1  high only in IDLE; decoded from state, no extra register.
REQ-009 SHALL have port: out_valid  output  1  result available; high only in HOLD.
REQ-010 SHALL have port: out_ack  input  1  consumer acknowledge of the result.
REQ-011 SHALL have port: diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
REQ-012 SHALL have port: bout  output  1  unsigned borrow-out: 1 iff a < b + bin.
REQ-013 SHALL have port: ovf  output  1  two's-complement overflow: borrow into MSB XOR borrow out of MSB.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, SHIFT, HOLD.
REQ-015 IDLE: start=1 at a rising edge SHALL load a, b into shift registers, bin into the borrow flop, clear the bit counter, and go to SHIFT.
REQ-016 SHIFT: each edge SHALL process one bit LSB-first through a single full-subtractor cell, shift the difference bit in at the MSB of the result shift register, and update the borrow flop.
REQ-017 After exactly WIDTH SHIFT edges, SHALL go to HOLD and load diff, bout and ovf registers on that same edge.
REQ-018 Latency SHALL be WIDTH cycles: accepting edge k gives out_valid=1 in the cycle following edge k+WIDTH.
REQ-019 HOLD: out_ack=1 at an edge SHALL return the FSM to IDLE; out_valid stays high until then, with no timeout.
REQ-020 diff, bout and ovf SHALL change only on entry to HOLD and SHALL stay stable through IDLE and SHIFT until the next HOLD entry.
REQ-021 start SHALL be ignored in SHIFT and HOLD, with no queuing.
REQ-022 start and out_ack both high in HOLD: the ack SHALL be taken, the start ignored, and the FSM SHALL move to IDLE.
REQ-023 out_ack outside HOLD SHALL be ignored.
REQ-024 Back-to-back operation: start in the first IDLE cycle after HOLD SHALL be accepted with no bubble.
REQ-025 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL not wrap within one operation.
REQ-026 Operands sampled at acceptance SHALL be the only ones used; a, b and bin changing during SHIFT SHALL not affect the result.

Reset
REQ-027 rst=1 SHALL force the following immediately, regardless of clk: state=IDLE, ready=1, out_valid=0, diff=0, bout=0, ovf=0, counter=0, shift registers=0, borrow flop=0.
REQ-028 rst asserted mid-SHIFT or in HOLD SHALL abort the operation; no partial result is ever presented.
REQ-029 The first edge after rst deasserts SHALL be able to accept start.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (IDLE/SHIFT/HOLD) and the default WIDTH constant.
REQ-031 The one-bit cell SHALL be a sub-module full_subtractor (inputs x, y, bi; outputs d, bo), built from gate primitives: d = x^y^bi, bo = (~x&y) | (~(x^y)&bi).
REQ-032 Exactly one full_subtractor instance SHALL be used; the datapath is bit-serial, not a ripple array.

Verification (WIDTH=4)
REQ-033 a=7, b=3, bin=0 -> after 4 cycles: diff=4, bout=0, ovf=0, out_valid=1.
REQ-034 a=3, b=5, bin=1 -> diff=13, bout=1, ovf=0; a=0, b=0, bin=1 -> diff=15, bout=1, ovf=0.
REQ-035 a=8, b=1, bin=0 -> diff=7, bout=0, ovf=1; a=7, b=15, bin=0 -> diff=8, bout=1, ovf=1.
REQ-036 Handshake: out_ack held low 10 cycles -> out_valid and diff stay stable; start pulsed in SHIFT and HOLD -> ignored; start one cycle after ack -> accepted, second result correct.
REQ-037 rst pulsed after 2 SHIFT edges of a=9, b=2 -> out_valid=0, ready=1, diff=0 immediately; next op a=6, b=6 -> diff=0, bout=0, ovf=0.
REQ-038 Randomized 1000 ops with random out_ack delays -> every result matches a - b - bin reference model, with latency exactly 4.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor built from gate primitives: d = x^y^bi, bo = ~x&y | ~(x^y)&bi.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    logic w_xy;
    logic w_nx;
    logic w_nxy;
    logic w_gen;
    logic w_prop;

    xor g_xy   (w_xy, x, y);
    xor g_d    (d, w_xy, bi);
    not g_nx   (w_nx, x);
    and g_gen  (w_gen, w_nx, y);
    not g_nxy  (w_nxy, w_xy);
    and g_prop (w_prop, w_nxy, bi);
    or  g_bo   (bo, w_gen, w_prop);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full_subtractor cell processes a - b - bin LSB-first over WIDTH cycles.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             out_valid,
    input  logic             out_ack,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    // Upper WIDTH-1 result bits; the newest difference bit completes the word.
    logic [WIDTH-2:0]   r_sh;
    logic               r_borrow;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_ovf;

    logic               w_d;
    logic               w_bo;
    logic               w_last;
    logic [WIDTH-1:0]   w_res;

    full_subtractor u_cell (
        .x  (r_a[0]),
        .y  (r_b[0]),
        .bi (r_borrow),
        .d  (w_d),
        .bo (w_bo)
    );

    assign w_res     = {w_d, r_sh};
    assign w_last    = (r_state == ST_SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));
    assign ready     = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_HOLD);
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign ovf       = r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start)   w_next = ST_SHIFT;
            ST_SHIFT: if (w_last)  w_next = ST_HOLD;
            ST_HOLD:  if (out_ack) w_next = ST_IDLE;
            default:               w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sh     <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= bin;
                        r_cnt    <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_sh     <= w_res[WIDTH-1:1];
                    r_borrow <= w_bo;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        // r_borrow is the borrow into the MSB on this edge.
                        r_diff <= w_res;
                        r_bout <= w_bo;
                        r_ovf  <= r_borrow ^ w_bo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
